// File: rtl/booth_mac_accumulator_pkg.sv
// Shared types and default constants for the Booth MAC accumulator slice.
package mac_pkg;

  localparam int DEF_PROD_W      = 8;
  localparam int DEF_ACC_W       = 16;
  localparam int DEF_CNT_W       = 8;
  localparam int DEF_ARM_TIMEOUT = 4;

  // Saturation limits of the default-width accumulator.
  localparam logic signed [DEF_ACC_W-1:0] ACC_MAX = {1'b0, {(DEF_ACC_W-1){1'b1}}};
  localparam logic signed [DEF_ACC_W-1:0] ACC_MIN = {1'b1, {(DEF_ACC_W-1){1'b0}}};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_RUN   = 2'd2
  } state_t;

endpackage

// File: rtl/booth_mac_accumulator_if.sv
// Bundles the multiplier-side inputs and the accumulator results.
interface booth_mac_accumulator_if #(
  parameter int PROD_W = 8,
  parameter int ACC_W  = 16,
  parameter int CNT_W  = 8
);
  logic              start;
  logic              busy;
  logic [PROD_W-1:0] ab;
  logic              clear;
  logic [ACC_W-1:0]  acc;
  logic [CNT_W-1:0]  count;
  logic              acc_valid;
  logic              overflow;
  logic              missed;

  modport master (
    output start, busy, ab, clear,
    input  acc, count, acc_valid, overflow, missed
  );

  modport slave (
    input  start, busy, ab, clear,
    output acc, count, acc_valid, overflow, missed
  );
endinterface

// File: rtl/booth_mac_accumulator_sat_adder.sv
// Combinational signed saturating adder: wide accumulator plus narrow product.
module sat_adder #(
  parameter int ACC_W  = 16,
  parameter int PROD_W = 8
) (
  input  logic signed [ACC_W-1:0]  a,
  input  logic signed [PROD_W-1:0] b,
  output logic signed [ACC_W-1:0]  sum,
  output logic                     sat
);

  localparam logic signed [ACC_W-1:0] SUM_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SUM_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  logic signed [ACC_W:0] w_wide;

  // Add with one guard bit; differing top two bits mean the result left the ACC_W range.
  always_comb begin
    w_wide = {a[ACC_W-1], a} + {{(ACC_W+1-PROD_W){b[PROD_W-1]}}, b};
    sum    = w_wide[ACC_W-1:0];
    sat    = 1'b0;
    if (w_wide[ACC_W] != w_wide[ACC_W-1]) begin
      sat = 1'b1;
      sum = w_wide[ACC_W] ? SUM_MIN : SUM_MAX;
    end
  end

endmodule

// File: rtl/booth_mac_accumulator.sv
// Follows start/busy transactions of the Booth multiplier and accumulates
// each finished product into a saturating signed sum with count and flags.
module booth_mac_accumulator
  import mac_pkg::*;
#(
  parameter int PROD_W      = DEF_PROD_W,
  parameter int ACC_W       = DEF_ACC_W,
  parameter int CNT_W       = DEF_CNT_W,
  parameter int ARM_TIMEOUT = DEF_ARM_TIMEOUT
) (
  input logic                   clk,
  input logic                   rst,
  booth_mac_accumulator_if.slave bus
);

  localparam int TMO_W = (ARM_TIMEOUT > 1) ? $clog2(ARM_TIMEOUT) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(ARM_TIMEOUT - 1);

  state_t                   r_state;
  state_t                   w_stateNext;
  logic [TMO_W-1:0]         r_tmo;
  logic [TMO_W-1:0]         w_tmoNext;
  logic                     w_doAdd;
  logic                     w_setMissed;

  logic signed [ACC_W-1:0]  r_acc;
  logic [CNT_W-1:0]         r_count;
  logic                     r_accValid;
  logic                     r_overflow;
  logic                     r_missed;

  logic signed [ACC_W-1:0]  w_addA;
  logic signed [ACC_W-1:0]  w_sum;
  logic                     w_sat;

  // A clear coinciding with an add restarts the sum from zero.
  assign w_addA = bus.clear ? '0 : r_acc;

  sat_adder #(
    .ACC_W  (ACC_W),
    .PROD_W (PROD_W)
  ) u_sat_adder (
    .a   (w_addA),
    .b   (bus.ab),
    .sum (w_sum),
    .sat (w_sat)
  );

  // State and arm-timeout counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_tmo   <= '0;
    end else begin
      r_state <= w_stateNext;
      r_tmo   <= w_tmoNext;
    end
  end

  // Next-state logic: arm on start, wait for busy, add when busy falls.
  always_comb begin
    w_stateNext = r_state;
    w_tmoNext   = r_tmo;
    w_doAdd     = 1'b0;
    w_setMissed = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.start) begin
          w_stateNext = ST_ARMED;
          w_tmoNext   = '0;
        end
      end
      ST_ARMED: begin
        if (bus.busy) begin
          w_stateNext = ST_RUN;
        end else if (r_tmo == TMO_LAST) begin
          w_stateNext = ST_IDLE;
          w_setMissed = 1'b1;
        end else begin
          w_tmoNext = r_tmo + 1'b1;
        end
      end
      ST_RUN: begin
        if (!bus.busy) begin
          w_doAdd     = 1'b1;
          w_stateNext = ST_IDLE;
        end
      end
      default: w_stateNext = ST_IDLE;
    endcase
  end

  // Accumulator, counter and sticky flags; a new missed event wins over a same-cycle clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc      <= '0;
      r_count    <= '0;
      r_accValid <= 1'b0;
      r_overflow <= 1'b0;
      r_missed   <= 1'b0;
    end else begin
      r_accValid <= w_doAdd;
      if (w_doAdd) begin
        r_acc      <= w_sum;
        r_overflow <= (bus.clear ? 1'b0 : r_overflow) | w_sat;
        if (bus.clear)
          r_count <= CNT_W'(1);
        else if (r_count != {CNT_W{1'b1}})
          r_count <= r_count + 1'b1;
      end else if (bus.clear) begin
        r_acc      <= '0;
        r_count    <= '0;
        r_overflow <= 1'b0;
      end
      if (w_setMissed)
        r_missed <= 1'b1;
      else if (bus.clear)
        r_missed <= 1'b0;
    end
  end

  assign bus.acc       = r_acc;
  assign bus.count     = r_count;
  assign bus.acc_valid = r_accValid;
  assign bus.overflow  = r_overflow;
  assign bus.missed    = r_missed;

endmodule
